md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Issue and scheduling controller for the multiply/divide datapath in the pipelined MIPS core.
- Decodes the E-stage instruction and launches mult/multu/div/divu on the external md datapath.
- Counts the fixed operation latency and owns the architectural HI/LO registers (including mthi/mtlo writes and mfhi/mflo reads).
- Produces the D-stage stall that holds md-class instructions while the unit is occupied.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (>=1)
- DIV_LAT, 10, busy cycles for div/divu (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- E_instr  in  32  instruction currently in E stage
- E_valid  in  1  E_instr is a real (non-bubble) instruction
- E_flush  in  1  E instruction is being cancelled (exception); suppresses every E-side action
- E_rs  in  32  forwarded GPR[rs] value in E
- E_rt  in  32  forwarded GPR[rt] value in E
- D_instr  in  32  instruction in D stage
- md_start  out  1  one-cycle launch pulse to datapath
- md_op  out  2  00 mult, 01 multu, 10 div, 11 divu; held while busy
- md_a  out  32  operand A, latched at issue, held while busy
- md_b  out  32  operand B, latched at issue, held while busy
- md_res_hi  in  32  datapath result high (product[63:32] / remainder)
- md_res_lo  in  32  datapath result low (product[31:0] / quotient)
- busy  out  1  operation in flight
- D_stall  out  1  stall D stage
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- E_mdout  out  32  mfhi -> HI, mflo -> LO, otherwise 0 (combinational)

Behaviour:
- Decode: opcode 000000 with funct
  - 011000 mult, 011001 multu, 011010 div, 011011 divu
  - 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo
  - Any other instruction is ignored by this block.
- "E action" means E_valid=1 and E_flush=0.
- Reset (async): HI, LO, md_a, md_b, md_op, counter, md_start, busy all 0; state IDLE. Reset mid-operation aborts the operation with no writeback.
- States: IDLE, RUN.
- IDLE, start-class E action in cycle k:
  - md_start=1 combinationally in cycle k.
  - At the end-of-k edge: latch md_op, md_a=E_rs, md_b=E_rt; cnt=MULT_LAT or DIV_LAT; enter RUN.
- RUN:
  - busy=1 for cycles k+1..k+LAT; cnt decrements each edge.
  - At the edge ending cycle k+LAT: HI<=md_res_hi, LO<=md_res_lo; return to IDLE.
  - busy=0 from cycle k+LAT+1.
  - The datapath must present its result by cycle k+LAT.
- div/divu with E_rt==0:
  - md_start is still pulsed and the full DIV_LAT is still counted, so timing is data-independent.
  - HI/LO are left unchanged at completion.
- mthi/mtlo E action in IDLE: HI (or LO) <= E_rs at the edge. Visible to an mfhi/mflo in E the following cycle.
- mfhi/mflo: E_mdout reads registered HI/LO. No internal bypass is needed because D_stall prevents overlap.
- Any md-class E action arriving while in RUN (a stall violation) is ignored. HI/LO and the operation in flight are unaffected.
- D_stall = (D_instr is md-class) AND (busy OR md_start).
- E_flush does not cancel an operation already in RUN.

Optional Feature:
- Macro: MD_MADD_EN.
- When defined, the block additionally decodes opcode 011100 with funct:
  - 000000 madd (md_op=00)
  - 000001 maddu (md_op=01)
  - 000100 msub (md_op=00)
- These ops run with MULT_LAT. At completion:
  - madd/maddu: {HI,LO} <= {HI,LO} + {md_res_hi,md_res_lo}
  - msub: {HI,LO} <= {HI,LO} - {md_res_hi,md_res_lo}
  - Arithmetic is 64-bit modulo 2^64, using the HI/LO values current at completion.
- These ops count as md-class for D_stall.
- When undefined, these encodings are ignored and are not md-class.

Test Plan:
- mult: E_rs=0xFFFFFFFE, E_rt=3, datapath returns 0xFFFFFFFF/0xFFFFFFFA -> md_start one cycle; busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- divu 7/2 with mflo in D behind it -> D_stall high for the issue cycle plus 10 busy cycles; then LO=3, HI=1, and E_mdout=3 when mflo reaches E.
- div with E_rt=0 after mthi 0x1234 / mtlo 0x5678 -> busy 10 cycles; HI=0x1234, LO=0x5678 unchanged.
- Reset asserted in the 3rd busy cycle of mult -> busy, HI, LO, md_a all 0 immediately (async); no later writeback.
- mult in E with E_flush=1 -> md_start=0, busy stays 0, HI/LO unchanged; next cycle mtlo 0xA5 -> LO=0xA5.
- (MD_MADD_EN) HI=0, LO=0xFFFFFFFF, madd with product 1 -> after 5 busy cycles HI=1, LO=0.

Source files
------------

// File: rtl/md_sched.sv
// md_sched: issue/scheduling controller for the multiply/divide unit.
// Launches mult/multu/div/divu on the external datapath, counts the fixed
// latency, owns HI/LO and generates the D-stage stall for md-class ops.
// Define MD_MADD_EN to add madd/maddu/msub (SPECIAL2) accumulate support.
module md_sched #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_instr,
    input  logic        E_valid,
    input  logic        E_flush,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic [31:0] D_instr,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic [31:0] md_res_hi,
    input  logic [31:0] md_res_lo,
    output logic        busy,
    output logic        D_stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_mdout
);
    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB} acc_t;

    localparam int CNT_W = 16;
    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
`ifdef MD_MADD_EN
    localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
`endif

    // Instruction classes that must wait for the md unit in D
    function automatic logic md_class(input logic [31:0] ins);
        logic r;
        r = 1'b0;
        if (ins[31:26] == OPC_SPECIAL) begin
            case (ins[5:0])
                6'b011000, 6'b011001, 6'b011010, 6'b011011,
                6'b010000, 6'b010001, 6'b010010, 6'b010011: r = 1'b1;
                default: r = 1'b0;
            endcase
        end
`ifdef MD_MADD_EN
        else if (ins[31:26] == OPC_SPECIAL2) begin
            case (ins[5:0])
                6'b000000, 6'b000001, 6'b000100: r = 1'b1;
                default: r = 1'b0;
            endcase
        end
`endif
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        dz_q, dz_d;
    acc_t        acc_q, acc_d;

    logic        e_act, e_start, e_isdiv, e_mfhi, e_mflo, e_mthi, e_mtlo;
    logic [1:0]  e_op;
    acc_t        e_acc;
    logic        start;
    logic [63:0] hilo_sum, hilo_dif;
    logic        unused_instr;

    // Register/shamt fields of the instruction words play no part here
    assign unused_instr = ^{E_instr[25:6], D_instr[25:6]};
    assign e_act = E_valid & ~E_flush;

    // Decode of the E-stage instruction
    always_comb begin
        e_start = 1'b0;
        e_isdiv = 1'b0;
        e_op    = 2'b00;
        e_acc   = ACC_SET;
        e_mfhi  = 1'b0;
        e_mflo  = 1'b0;
        e_mthi  = 1'b0;
        e_mtlo  = 1'b0;
        if (E_instr[31:26] == OPC_SPECIAL) begin
            case (E_instr[5:0])
                6'b011000: begin e_start = 1'b1; e_op = 2'b00; end
                6'b011001: begin e_start = 1'b1; e_op = 2'b01; end
                6'b011010: begin e_start = 1'b1; e_op = 2'b10; e_isdiv = 1'b1; end
                6'b011011: begin e_start = 1'b1; e_op = 2'b11; e_isdiv = 1'b1; end
                6'b010000: e_mfhi = 1'b1;
                6'b010010: e_mflo = 1'b1;
                6'b010001: e_mthi = 1'b1;
                6'b010011: e_mtlo = 1'b1;
                default: ;
            endcase
        end
`ifdef MD_MADD_EN
        else if (E_instr[31:26] == OPC_SPECIAL2) begin
            case (E_instr[5:0])
                6'b000000: begin e_start = 1'b1; e_op = 2'b00; e_acc = ACC_ADD; end
                6'b000001: begin e_start = 1'b1; e_op = 2'b01; e_acc = ACC_ADD; end
                6'b000100: begin e_start = 1'b1; e_op = 2'b00; e_acc = ACC_SUB; end
                default: ;
            endcase
        end
`endif
    end

    // Next-state: issue in IDLE, count down and write back in RUN
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        dz_d     = dz_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hilo_sum = {hi_q, lo_q} + {md_res_hi, md_res_lo};
        hilo_dif = {hi_q, lo_q} - {md_res_hi, md_res_lo};
        start    = ~reset & (state_q == IDLE) & e_act & e_start;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    op_d    = e_op;
                    a_d     = E_rs;
                    b_d     = E_rt;
                    acc_d   = e_acc;
                    dz_d    = e_isdiv & (E_rt == 32'd0);
                    cnt_d   = e_isdiv ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                end else if (e_act & e_mthi) begin
                    hi_d = E_rs;
                end else if (e_act & e_mtlo) begin
                    lo_d = E_rs;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    if (!dz_q) begin
                        case (acc_q)
                            ACC_ADD: {hi_d, lo_d} = hilo_sum;
                            ACC_SUB: {hi_d, lo_d} = hilo_dif;
                            default: begin
                                hi_d = md_res_hi;
                                lo_d = md_res_lo;
                            end
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and architectural registers; reset aborts any operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            dz_q    <= 1'b0;
            acc_q   <= ACC_SET;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dz_q    <= dz_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md_start = start;
    assign md_op    = op_q;
    assign md_a     = a_q;
    assign md_b     = b_q;
    assign busy     = (state_q == RUN);
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign D_stall  = md_class(D_instr) & (busy | start);
    assign E_mdout  = e_mfhi ? hi_q : (e_mflo ? lo_q : 32'd0);

endmodule

// File: tb/tb_md_sched.sv
// Testbench for md_sched: decode table, directed multi-cycle sequences and
// a randomized run against a cycle-level reference model.
module tb_md_sched;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
`ifdef MD_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic        clk, reset;
    logic [31:0] E_instr, E_rs, E_rt, D_instr, md_res_hi, md_res_lo;
    logic        E_valid, E_flush;
    logic        md_start, busy, D_stall;
    logic [1:0]  md_op;
    logic [31:0] md_a, md_b, HI, LO, E_mdout;

    int n_cmp = 0;
    int n_bad = 0;

    md_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .E_instr(E_instr), .E_valid(E_valid),
        .E_flush(E_flush), .E_rs(E_rs), .E_rt(E_rt), .D_instr(D_instr),
        .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
        .md_res_hi(md_res_hi), .md_res_lo(md_res_lo), .busy(busy),
        .D_stall(D_stall), .HI(HI), .LO(LO), .E_mdout(E_mdout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Kinds: 0 mult 1 multu 2 div 3 divu 4 mfhi 5 mflo 6 mthi 7 mtlo
    // 8 addu 9 addi(funct bits look like mult) 10 madd 11 maddu 12 msub
    function automatic logic [31:0] enc(input int k, input logic [19:0] fill);
        logic [5:0] opc, fn;
        opc = 6'b000000;
        fn  = 6'b100001;
        case (k)
            0: fn = 6'b011000;
            1: fn = 6'b011001;
            2: fn = 6'b011010;
            3: fn = 6'b011011;
            4: fn = 6'b010000;
            5: fn = 6'b010010;
            6: fn = 6'b010001;
            7: fn = 6'b010011;
            9: begin opc = 6'b001000; fn = 6'b011000; end
            10: begin opc = 6'b011100; fn = 6'b000000; end
            11: begin opc = 6'b011100; fn = 6'b000001; end
            12: begin opc = 6'b011100; fn = 6'b000100; end
            default: ;
        endcase
        return {opc, fill, fn};
    endfunction

    function automatic bit k_start(input int k);
        return (k <= 3) || (MADD && k >= 10 && k <= 12);
    endfunction

    function automatic bit k_md(input int k);
        return (k <= 7) || (MADD && k >= 10 && k <= 12);
    endfunction

    function automatic logic [1:0] k_op(input int k);
        case (k)
            1, 11: return 2'b01;
            2: return 2'b10;
            3: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // What an ideal datapath returns for the operation: {hi, lo}
    function automatic logic [63:0] dp_result(input int k, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        case (k)
            0, 10, 12: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            1, 11: return {32'd0, a} * {32'd0, b};
            2: begin
                if (b == 32'd0) return 64'hDEADBEEF_0BADF00D;
                return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end
            3: begin
                if (b == 32'd0) return 64'hDEADBEEF_0BADF00D;
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic f,
                         input logic [31:0] rs, input logic [31:0] rt, input int dk);
        E_instr = enc(k, 20'h0);
        E_valid = v;
        E_flush = f;
        E_rs    = rs;
        E_rt    = rt;
        D_instr = enc(dk, 20'h0);
    endtask

    typedef struct {
        int          ek;
        logic        v;
        logic        f;
        logic [31:0] rs;
        int          dk;
        logic        x_start;
        logic        x_stall;
        logic [31:0] x_mdout;
        logic [31:0] x_hi;
        logic [31:0] x_lo;
    } vec_t;

    vec_t tbl[9];

    // Reference model state
    int          m_rem;
    int          m_kind;
    logic [31:0] m_a, m_b, m_hi, m_lo;
    bit          m_dz;

    initial begin
        tbl[0] = '{6, 1, 0, 32'h11112222, 8, 0, 0, 32'h0, 32'h11112222, 32'h0};
        tbl[1] = '{7, 1, 0, 32'h33334444, 4, 0, 0, 32'h0, 32'h11112222, 32'h33334444};
        tbl[2] = '{4, 1, 0, 32'h0,        8, 0, 0, 32'h11112222, 32'h11112222, 32'h33334444};
        tbl[3] = '{5, 1, 0, 32'h0,        0, 0, 0, 32'h33334444, 32'h11112222, 32'h33334444};
        tbl[4] = '{0, 0, 0, 32'h7,        5, 0, 0, 32'h0, 32'h11112222, 32'h33334444};
        tbl[5] = '{0, 1, 1, 32'h7,        0, 0, 0, 32'h0, 32'h11112222, 32'h33334444};
        tbl[6] = '{6, 1, 1, 32'hDEAD,     8, 0, 0, 32'h0, 32'h11112222, 32'h33334444};
        tbl[7] = '{7, 0, 0, 32'hBEEF,     6, 0, 0, 32'h0, 32'h11112222, 32'h33334444};
        tbl[8] = '{9, 1, 0, 32'h5,        8, 0, 0, 32'h0, 32'h11112222, 32'h33334444};

        reset = 1'b1;
        drive(8, 0, 0, 0, 0, 8);
        md_res_hi = 32'h0;
        md_res_lo = 32'h0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, md_start}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        step();
        step();
        reset = 1'b0;

        // Single-cycle decode / HI-LO access table
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].ek, tbl[i].v, tbl[i].f, tbl[i].rs, 32'h3, tbl[i].dk);
            #1;
            chk($sformatf("tbl%0d_start", i), {31'd0, md_start}, {31'd0, tbl[i].x_start});
            chk($sformatf("tbl%0d_stall", i), {31'd0, D_stall}, {31'd0, tbl[i].x_stall});
            chk($sformatf("tbl%0d_mdout", i), E_mdout, tbl[i].x_mdout);
            step();
            chk($sformatf("tbl%0d_hi", i), HI, tbl[i].x_hi);
            chk($sformatf("tbl%0d_lo", i), LO, tbl[i].x_lo);
        end

        // mult -2 * 3
        drive(0, 1, 0, 32'hFFFFFFFE, 32'd3, 8);
        md_res_hi = 32'hFFFFFFFF;
        md_res_lo = 32'hFFFFFFFA;
        #1;
        chk("mult_start", {31'd0, md_start}, 32'd1);
        chk("mult_busy0", {31'd0, busy}, 32'd0);
        step();
        drive(8, 1, 0, 0, 0, 8);
        #1;
        chk("mult_start_pulse", {31'd0, md_start}, 32'd0);
        chk("mult_a", md_a, 32'hFFFFFFFE);
        chk("mult_b", md_b, 32'd3);
        chk("mult_op", {30'd0, md_op}, 32'd0);
        for (int i = 0; i < MULT_LAT; i++) begin
            chk($sformatf("mult_busy%0d", i + 1), {31'd0, busy}, 32'd1);
            step();
        end
        chk("mult_done_busy", {31'd0, busy}, 32'd0);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);

        // divu 7/2 with mflo waiting in D
        drive(3, 1, 0, 32'd7, 32'd2, 5);
        md_res_hi = 32'd1;
        md_res_lo = 32'd3;
        #1;
        chk("divu_start", {31'd0, md_start}, 32'd1);
        chk("divu_stall_issue", {31'd0, D_stall}, 32'd1);
        step();
        drive(8, 1, 0, 0, 0, 5);
        for (int i = 0; i < DIV_LAT; i++) begin
            #1;
            chk($sformatf("divu_stall%0d", i + 1), {31'd0, D_stall}, 32'd1);
            step();
        end
        #1;
        chk("divu_stall_end", {31'd0, D_stall}, 32'd0);
        chk("divu_hi", HI, 32'd1);
        chk("divu_lo", LO, 32'd3);
        drive(5, 1, 0, 0, 0, 8);
        #1;
        chk("divu_mflo", E_mdout, 32'd3);
        step();

        // div by zero leaves HI/LO untouched but keeps full latency
        drive(6, 1, 0, 32'h1234, 0, 8);
        step();
        drive(7, 1, 0, 32'h5678, 0, 8);
        step();
        drive(2, 1, 0, 32'd5, 32'd0, 8);
        md_res_hi = 32'hBAD0BAD0;
        md_res_lo = 32'hBAD1BAD1;
        #1;
        chk("dz_start", {31'd0, md_start}, 32'd1);
        step();
        drive(8, 1, 0, 0, 0, 8);
        for (int i = 0; i < DIV_LAT; i++) begin
            chk($sformatf("dz_busy%0d", i + 1), {31'd0, busy}, 32'd1);
            step();
        end
        chk("dz_busy_end", {31'd0, busy}, 32'd0);
        chk("dz_hi", HI, 32'h1234);
        chk("dz_lo", LO, 32'h5678);

        // Async reset in the third busy cycle of a mult
        drive(0, 1, 0, 32'd3, 32'd4, 8);
        md_res_hi = 32'd0;
        md_res_lo = 32'd12;
        step();
        drive(8, 1, 0, 0, 0, 8);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_hi", HI, 32'd0);
        chk("rstmid_lo", LO, 32'd0);
        chk("rstmid_a", md_a, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("rstmid_nowb_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_nowb_lo", LO, 32'd0);

        // Flushed mult does nothing, mtlo right after works
        drive(0, 1, 1, 32'd9, 32'd9, 8);
        #1;
        chk("flush_start", {31'd0, md_start}, 32'd0);
        step();
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", HI, 32'd0);
        drive(7, 1, 0, 32'hA5, 0, 8);
        step();
        chk("flush_mtlo", LO, 32'hA5);

`ifdef MD_MADD_EN
        drive(6, 1, 0, 32'h0, 0, 8);
        step();
        drive(7, 1, 0, 32'hFFFFFFFF, 0, 8);
        step();
        drive(10, 1, 0, 32'd1, 32'd1, 8);
        md_res_hi = 32'd0;
        md_res_lo = 32'd1;
        #1;
        chk("madd_start", {31'd0, md_start}, 32'd1);
        step();
        drive(8, 1, 0, 0, 0, 8);
        for (int i = 0; i < MULT_LAT; i++) begin
            chk($sformatf("madd_busy%0d", i + 1), {31'd0, busy}, 32'd1);
            step();
        end
        chk("madd_hi", HI, 32'd1);
        chk("madd_lo", LO, 32'd0);
`endif

        // Randomized run against the reference model
        reset = 1'b1;
        drive(8, 0, 0, 0, 0, 8);
        step();
        reset = 1'b0;
        m_rem = 0; m_kind = 0; m_a = 0; m_b = 0; m_hi = 0; m_lo = 0; m_dz = 0;
        for (int c = 0; c < 800; c++) begin
            int k, dk;
            logic v, f;
            logic [31:0] rs, rt, x_mdout;
            logic [63:0] r;
            bit x_start, x_busy, x_stall;
            k  = $urandom_range(0, 12);
            dk = $urandom_range(0, 12);
            v  = ($urandom_range(0, 7) != 0);
            f  = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rt = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom);
            E_instr = enc(k, 20'($urandom));
            D_instr = enc(dk, 20'($urandom));
            E_valid = v; E_flush = f; E_rs = rs; E_rt = rt;
            if (m_rem > 0) {md_res_hi, md_res_lo} = dp_result(m_kind, m_a, m_b);
            else {md_res_hi, md_res_lo} = {$urandom, $urandom};
            #1;
            x_busy  = (m_rem > 0);
            x_start = !x_busy && v && !f && k_start(k);
            x_stall = k_md(dk) && (x_busy || x_start);
            x_mdout = (k == 4) ? m_hi : ((k == 5) ? m_lo : 32'd0);
            chk("rnd_start", {31'd0, md_start}, {31'd0, x_start});
            chk("rnd_busy", {31'd0, busy}, {31'd0, x_busy});
            chk("rnd_stall", {31'd0, D_stall}, {31'd0, x_stall});
            chk("rnd_hi", HI, m_hi);
            chk("rnd_lo", LO, m_lo);
            if (v) chk("rnd_mdout", E_mdout, x_mdout);
            if (x_busy) begin
                chk("rnd_a", md_a, m_a);
                chk("rnd_b", md_b, m_b);
                chk("rnd_op", {30'd0, md_op}, {30'd0, k_op(m_kind)});
            end
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0 && !m_dz) begin
                    r = dp_result(m_kind, m_a, m_b);
                    if (m_kind == 10 || m_kind == 11) {m_hi, m_lo} = {m_hi, m_lo} + r;
                    else if (m_kind == 12) {m_hi, m_lo} = {m_hi, m_lo} - r;
                    else {m_hi, m_lo} = r;
                end
            end else if (x_start) begin
                m_kind = k;
                m_a    = rs;
                m_b    = rt;
                m_dz   = (k == 2 || k == 3) && (rt == 32'd0);
                m_rem  = (k == 2 || k == 3) ? DIV_LAT : MULT_LAT;
            end else if (v && !f && k == 6) begin
                m_hi = rs;
            end else if (v && !f && k == 7) begin
                m_lo = rs;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
